brpuf_eval_ctrl: RTL
====================

BRPUF_EVAL_CTRL -- requirements
Module: brpuf_eval_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: ring reset hold cycles per evaluation, legal range 1..65535.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024: ring free-run cycles before sampling, legal range 4..65535.
REQ-003 SHALL have parameter NUM_EVALS, default 7: evaluations per challenge; must be odd, 1..255; an even value SHALL be an elaboration error.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port chal_in, input, 64 bits: challenge to evaluate.
REQ-007 SHALL have port chal_valid, input, 1 bit: chal_in valid.
REQ-008 SHALL have port chal_ready, output, 1 bit: block can accept a challenge.
REQ-009 SHALL have port ring_chal, output, 64 bits: challenge driven to the 64-stage bistable ring.
REQ-010 SHALL have port ring_rst, output, 1 bit: ring reset, active-high.
REQ-011 SHALL have port p_bit, input, 1 bit: ring response tap; asynchronous to clk.
REQ-012 SHALL have port resp_bit, output, 1 bit: majority-voted response.
REQ-013 SHALL have port resp_stable, output, 1 bit: all NUM_EVALS samples agreed.
REQ-014 SHALL have port resp_valid, output, 1 bit: resp_bit and resp_stable valid.
REQ-015 SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL pass p_bit through a 2-flop synchronizer; the sampled value is the synchronizer output (p_sync).
REQ-018 SHALL implement FSM states IDLE, RESET, SETTLE, SAMPLE, DONE.
REQ-019 IDLE: chal_ready=1, ring_rst=1; on chal_valid=1, SHALL latch chal_in into ring_chal, clear ones_cnt and eval_cnt, and go to RESET.
REQ-020 RESET: ring_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE.
REQ-021 SETTLE: ring_rst=0 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-022 SAMPLE: one cycle, ring_rst=0; SHALL do ones_cnt += p_sync and eval_cnt += 1; if the new eval_cnt equals NUM_EVALS go to DONE, else go to RESET.
REQ-023 DONE: ring_rst=1 and resp_valid=1.
REQ-024 In DONE, resp_bit SHALL equal (ones_cnt > NUM_EVALS/2), using integer division.
REQ-025 In DONE, resp_stable SHALL equal (ones_cnt==0 or ones_cnt==NUM_EVALS).
REQ-026 In DONE, resp_valid, resp_bit and resp_stable SHALL hold stable until resp_ready=1, then go to IDLE.
REQ-027 resp_valid SHALL first be high exactly NUM_EVALS*(RST_CYCLES+SETTLE_CYCLES+1) cycles after the challenge-accept edge.
REQ-028 ring_chal SHALL remain constant from acceptance until the next acceptance.
REQ-029 chal_ready SHALL be 0 outside IDLE; chal_valid outside IDLE SHALL be ignored.
REQ-030 resp_ready outside DONE SHALL be ignored.
REQ-031 DONE with resp_ready=1 SHALL go to IDLE; no challenge is accepted in that same cycle; chal_ready rises the following cycle.
REQ-032 ones_cnt and eval_cnt SHALL be 8 bits wide and SHALL never wrap, given the NUM_EVALS bound.
REQ-033 The phase counter SHALL be 16 bits wide and SHALL reload on every state entry.
REQ-034 resp_valid SHALL be 0 in every state except DONE.
REQ-035 resp_bit and resp_stable SHALL be 0 in every state except DONE.

Reset
REQ-036 rst=1 SHALL, at the next edge, force state IDLE.
REQ-037 rst=1 SHALL set ring_rst=1, ring_chal=0, and ones_cnt, eval_cnt and the phase counter to 0.
REQ-038 rst=1 SHALL set resp_valid=0, resp_bit=0, resp_stable=0 and busy=0.
REQ-039 rst=1 SHALL clear both synchronizer flops to 0.
REQ-040 rst=1 SHALL set chal_ready=1 from the first cycle after rst deasserts.
REQ-041 rst in any state, including mid-SETTLE or DONE, SHALL abandon the evaluation with no response produced.

Verification (RST_CYCLES=2, SETTLE_CYCLES=4, NUM_EVALS=3)
REQ-042 p_bit held 1, challenge 64'hDEADBEEF_01234567 accepted -> ring_chal=64'hDEADBEEF_01234567; resp_valid rises 21 cycles after accept; resp_bit=1, resp_stable=1.
REQ-043 p_bit set to 1,0,1 at the three SAMPLE cycles (stable through each SETTLE) -> resp_bit=1, resp_stable=0; pattern 0,1,0 -> resp_bit=0, resp_stable=0.
REQ-044 resp_ready held 0 for 10 cycles after resp_valid -> outputs unchanged throughout; resp_ready=1 -> IDLE next cycle; chal_ready=1 one cycle later.
REQ-045 chal_valid pulsed with a new chal_in while busy -> ignored; ring_chal unchanged; exactly one response produced.
REQ-046 rst asserted during the 2nd SETTLE -> next cycle state is IDLE, ring_rst=1, ring_chal=0, busy=0, and no resp_valid is produced.
REQ-047 ring_rst waveform for one challenge -> high 2, low 5, repeated 3 times, then high in DONE.

Source files
------------

// File: rtl/brpuf_eval_ctrl.sv
// Evaluation controller for a 64-stage bistable-ring PUF: per challenge, runs
// NUM_EVALS reset/settle/sample rounds and reports the majority-voted bit.
module brpuf_eval_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int NUM_EVALS     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] chal_in,
  input  logic        chal_valid,
  output logic        chal_ready,
  output logic [63:0] ring_chal,
  output logic        ring_rst,
  input  logic        p_bit,
  output logic        resp_bit,
  output logic        resp_stable,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        busy
);

  generate
    if ((NUM_EVALS % 2) == 0 || NUM_EVALS < 1 || NUM_EVALS > 255 ||
        RST_CYCLES < 1 || RST_CYCLES > 65535 ||
        SETTLE_CYCLES < 4 || SETTLE_CYCLES > 65535) begin : g_bad_param
      $error("brpuf_eval_ctrl: illegal parameter value (NUM_EVALS must be odd, 1..255)");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Phase counter holds "cycles remaining minus one" for the current state.
  localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  EVALS       = 8'(NUM_EVALS);
  localparam logic [7:0]  HALF        = 8'(NUM_EVALS / 2);

  logic [2:0]  state;
  logic [15:0] phase;
  logic [7:0]  ones_cnt;
  logic [7:0]  eval_cnt;
  logic [7:0]  eval_next;
  logic        p_meta;
  logic        p_sync;
  logic        in_done;

  assign eval_next = eval_cnt + 8'd1;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values, which keeps the synchronizer a true 2-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 16'd0;
      ones_cnt  <= 8'd0;
      eval_cnt  <= 8'd0;
      ring_chal <= 64'd0;
      p_meta    <= 1'b0;
      p_sync    <= 1'b0;
    end else begin
      p_meta <= p_bit;
      p_sync <= p_meta;
      case (state)
        S_IDLE: begin
          if (chal_valid) begin
            ring_chal <= chal_in;
            ones_cnt  <= 8'd0;
            eval_cnt  <= 8'd0;
            phase     <= RST_LOAD;
            state     <= S_RESET;
          end
        end
        S_RESET: begin
          if (phase == 16'd0) begin
            phase <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        S_SETTLE: begin
          if (phase == 16'd0) begin
            phase <= 16'd0;
            state <= S_SAMPLE;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        S_SAMPLE: begin
          ones_cnt <= ones_cnt + {7'd0, p_sync};
          eval_cnt <= eval_next;
          if (eval_next == EVALS) begin
            phase <= 16'd0;
            state <= S_DONE;
          end else begin
            phase <= RST_LOAD;
            state <= S_RESET;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            phase <= 16'd0;
            state <= S_IDLE;
          end
        end
        default: begin
          phase <= 16'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_done     = (state == S_DONE);
  assign chal_ready  = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign ring_rst    = (state != S_SETTLE) && (state != S_SAMPLE);
  assign resp_valid  = in_done;
  assign resp_bit    = in_done && (ones_cnt > HALF);
  assign resp_stable = in_done && ((ones_cnt == 8'd0) || (ones_cnt == EVALS));

endmodule
